otter_intc: RTL and testbench

- Parametrised multi-source interrupt controller for the OTTER.
- Generalises the MCU's single `intr` pin to NUM_SRC independently enabled channels, each edge- or level-triggered.
- Presents one registered `irq` to the MCU `intr` input; the MCU still gates it with mstatus.MIE.
- Software manages it through memory-mapped registers on the existing iobus (iobus_addr / iobus_out / iobus_wr).

---
 rtl/otter_intc.sv | 195 +++++++++++++++++++
 tb/tb_otter_intc.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_intc.sv
// otter_intc: multi-source interrupt controller on the OTTER iobus.
// Macro OTTER_INTC_RR_EN selects round-robin CLAIM arbitration.
//
// Ports:
//   clk        system clock, rising edge
//   RST_N      asynchronous active-low reset
//   src_irq    raw asynchronous requests, bit i = source i
//   iobus_addr MCU iobus address
//   iobus_out  MCU iobus write data
//   iobus_wr   MCU iobus write strobe
//   rd_data    combinational read data, 0 when not hit
//   rd_hit     iobus_addr inside the 32-byte register window
//   irq        registered request to MCU intr
module otter_intc #(
    parameter int unsigned NUM_SRC     = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h1100_0100,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               RST_N,
    input  logic [NUM_SRC-1:0] src_irq,
    input  logic [31:0]        iobus_addr,
    input  logic [31:0]        iobus_out,
    input  logic               iobus_wr,
    output logic [31:0]        rd_data,
    output logic               rd_hit,
    output logic               irq
);

    typedef logic [NUM_SRC-1:0] vec_t;

    logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q;
    vec_t s;
    vec_t s_d;
    vec_t pend;
    vec_t en;
    vec_t mode;
    logic [4:0] last_id;

    vec_t rise;
    vec_t clr;
    vec_t act;
    vec_t pend_nxt;

    logic [2:0] reg_sel;
    logic       wr_en;
    logic       wr_pend;
    logic       wr_en_reg;
    logic       wr_mode;
    logic       wr_claim;
    logic       cmp_ok;
    logic [4:0] cmp_id;
    vec_t       cmp_mask;

    logic [4:0] start;
    logic [2*NUM_SRC-1:0] dbl;
    vec_t       rot;
    logic       sel_found;
    logic [4:0] rot_k;
    logic [5:0] sel_sum;
    logic [4:0] sel_id;
    logic [7:0] act_cnt;

    logic unused_addr;

    // Synchroniser and edge history
    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            sync_q <= '0;
            s_d    <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], src_irq};
            s_d    <= s;
        end
    end

    // Register window decode
    assign rd_hit    = (iobus_addr[31:5] == BASE_ADDR[31:5]);
    assign reg_sel   = iobus_addr[4:2];
    assign wr_en     = iobus_wr & rd_hit;
    assign wr_pend   = wr_en && (reg_sel == 3'd0);
    assign wr_en_reg = wr_en && (reg_sel == 3'd1);
    assign wr_mode   = wr_en && (reg_sel == 3'd2);
    assign wr_claim  = wr_en && (reg_sel == 3'd3);

    assign unused_addr = ^iobus_addr[1:0];

    // CLAIM completion: value v in 1..NUM_SRC names source v-1
    assign cmp_ok   = (iobus_out != 32'd0) &&
                      (iobus_out <= 32'(NUM_SRC));
    assign cmp_id   = iobus_out[4:0] - 5'd1;
    assign cmp_mask = vec_t'(1) << cmp_id;

    // Pending next state: edge bits set on rising edge (set beats
    // clear); level bits simply track the synchronised input.
    always_comb begin
        clr = '0;
        if (wr_pend) begin
            clr = clr | iobus_out[NUM_SRC-1:0];
        end
        if (wr_claim && cmp_ok) begin
            clr = clr | cmp_mask;
        end
    end

    assign rise     = s & ~s_d;
    assign pend_nxt = (mode & ((pend & ~clr) | rise)) | (~mode & s);
    assign act      = pend & en;

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            pend <= '0;
            en   <= '0;
            mode <= '0;
            irq  <= 1'b0;
        end else begin
            pend <= pend_nxt;
            irq  <= |act;
            if (wr_en_reg) begin
                en <= iobus_out[NUM_SRC-1:0];
            end
            if (wr_mode) begin
                mode <= iobus_out[NUM_SRC-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
`ifdef OTTER_INTC_RR_EN
            last_id <= 5'(NUM_SRC - 1);
`else
            last_id <= '0;
`endif
        end else if (wr_claim && cmp_ok) begin
            last_id <= cmp_id;
        end
    end

    // Arbitration: rotate active vector so the search starts at
    // 'start', take lowest set bit, then rotate the index back.
`ifdef OTTER_INTC_RR_EN
    assign start = (last_id >= 5'(NUM_SRC - 1)) ? 5'd0
                                                : last_id + 5'd1;
`else
    logic unused_last;
    assign unused_last = ^last_id;
    assign start = 5'd0;
`endif

    assign dbl = {act, act} >> start;
    assign rot = dbl[NUM_SRC-1:0];

    always_comb begin
        sel_found = 1'b0;
        rot_k     = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sel_found = 1'b1;
                rot_k     = 5'(k);
            end
        end
    end

    assign sel_sum = {1'b0, start} + {1'b0, rot_k};
    assign sel_id  = (sel_sum >= 6'(NUM_SRC))
                   ? 5'(sel_sum - 6'(NUM_SRC))
                   : sel_sum[4:0];

    always_comb begin
        act_cnt = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            act_cnt = act_cnt + 8'(act[k]);
        end
    end

    // Read mux
    always_comb begin
        rd_data = '0;
        if (rd_hit) begin
            unique case (reg_sel)
                3'd0:    rd_data = 32'(pend);
                3'd1:    rd_data = 32'(en);
                3'd2:    rd_data = 32'(mode);
                3'd3:    rd_data = sel_found ? 32'(sel_id) + 32'd1
                                             : 32'd0;
                3'd4:    rd_data = {16'd0, act_cnt, 7'd0, irq};
                default: rd_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_otter_intc.sv
// tb_otter_intc: directed bench for otter_intc with a behavioural
// register-level model compared on every falling edge.
module tb_otter_intc;

    localparam int          N    = 8;
    localparam int          SS   = 2;
    localparam logic [31:0] BASE = 32'h1100_0100;

    localparam logic [31:0] A_PEND   = BASE + 32'h00;
    localparam logic [31:0] A_EN     = BASE + 32'h04;
    localparam logic [31:0] A_MODE   = BASE + 32'h08;
    localparam logic [31:0] A_CLAIM  = BASE + 32'h0C;
    localparam logic [31:0] A_STATUS = BASE + 32'h10;

    logic         clk;
    logic         RST_N;
    logic [N-1:0] src_irq;
    logic [31:0]  iobus_addr;
    logic [31:0]  iobus_out;
    logic         iobus_wr;
    logic [31:0]  rd_data;
    logic         rd_hit;
    logic         irq;

    int checks = 0;
    int errors = 0;

    otter_intc #(
        .NUM_SRC    (N),
        .BASE_ADDR  (BASE),
        .SYNC_STAGES(SS)
    ) dut (
        .clk       (clk),
        .RST_N     (RST_N),
        .src_irq   (src_irq),
        .iobus_addr(iobus_addr),
        .iobus_out (iobus_out),
        .iobus_wr  (iobus_wr),
        .rd_data   (rd_data),
        .rd_hit    (rd_hit),
        .irq       (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model
    bit [N-1:0] m_p;
    bit [N-1:0] m_en;
    bit [N-1:0] m_mode;
    bit         m_irq;
    int         m_last;
    // hist[k]: src_irq as sampled k+1 edges ago; a source is seen
    // by the controller SS-1 edges after it is first sampled.
    bit [N-1:0] hist [SS+1];

    function automatic bit in_win(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < 32);
    endfunction

    function automatic int exp_claim();
        bit [N-1:0] a;
        int         st;
        a = m_p & m_en;
`ifdef OTTER_INTC_RR_EN
        st = (m_last + 1) % N;
`else
        st = 0;
`endif
        for (int k = 0; k < N; k++) begin
            if (a[(st + k) % N]) return ((st + k) % N) + 1;
        end
        return 0;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        int off;
        if (!in_win(a)) return 32'd0;
        off = int'(a - BASE) / 4;
        case (off)
            0: return 32'(m_p);
            1: return 32'(m_en);
            2: return 32'(m_mode);
            3: return 32'(exp_claim());
            4: return ($countones(m_p & m_en) << 8) | 32'(m_irq);
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge RST_N) begin
        bit [N-1:0] s, sd, rise, clr, np;
        int         off;
        int         v;
        if (!RST_N) begin
            m_p    <= '0;
            m_en   <= '0;
            m_mode <= '0;
            m_irq  <= 1'b0;
`ifdef OTTER_INTC_RR_EN
            m_last <= N - 1;
`else
            m_last <= 0;
`endif
            for (int k = 0; k <= SS; k++) hist[k] <= '0;
        end else begin
            s    = hist[SS-1];
            sd   = hist[SS];
            rise = s & ~sd;
            clr  = '0;
            off  = -1;
            v    = int'(iobus_out);
            if (iobus_wr && in_win(iobus_addr)) begin
                off = int'(iobus_addr - BASE) / 4;
            end
            if (off == 0) clr = iobus_out[N-1:0];
            if (off == 3 && iobus_out >= 1 && iobus_out <= N) begin
                clr[v-1] = 1'b1;
                m_last  <= v - 1;
            end
            for (int i = 0; i < N; i++) begin
                if (m_mode[i]) np[i] = rise[i] | (m_p[i] & ~clr[i]);
                else           np[i] = s[i];
            end
            m_irq <= |(m_p & m_en);
            m_p   <= np;
            if (off == 1) m_en   <= iobus_out[N-1:0];
            if (off == 2) m_mode <= iobus_out[N-1:0];
            for (int k = SS; k > 0; k--) hist[k] <= hist[k-1];
            hist[0] <= src_irq;
        end
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, got, exp,
                     $time);
        end
    endtask

    // Compare process
    always @(negedge clk) begin
        chk("cmp_irq", {31'd0, irq}, {31'd0, m_irq});
        chk("cmp_hit", {31'd0, rd_hit}, {31'd0, in_win(iobus_addr)});
        chk("cmp_rd", rd_data, exp_rd(iobus_addr));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        iobus_addr = a;
        iobus_out  = d;
        iobus_wr   = 1'b1;
        @(posedge clk);
        #2;
        iobus_wr = 1'b0;
    endtask

    task automatic rdchk(input string nm, input logic [31:0] a,
                         input logic [31:0] exp);
        iobus_addr = a;
        #1;
        chk(nm, rd_data, exp);
    endtask

    task automatic irqchk(input string nm, input logic exp);
        chk(nm, {31'd0, irq}, {31'd0, exp});
    endtask

    initial begin
        RST_N      = 1'b0;
        src_irq    = '0;
        iobus_addr = A_PEND;
        iobus_out  = '0;
        iobus_wr   = 1'b0;
        tick(3);
        RST_N = 1'b1;
        tick(1);

        // Reset state
        irqchk("rst_irq", 1'b0);
        rdchk("rst_pend", A_PEND, 32'h0);
        rdchk("rst_en", A_EN, 32'h0);
        rdchk("rst_claim", A_CLAIM, 32'h0);

        // Edge latency on source 0
        wr(A_EN, 32'h01);
        wr(A_MODE, 32'h01);
        src_irq[0] = 1'b1;
        tick(2);
        rdchk("lat_pend_e1", A_PEND, 32'h0);
        tick(1);
        rdchk("lat_pend_e2", A_PEND, 32'h1);
        irqchk("lat_irq_e2", 1'b0);
        tick(1);
        irqchk("lat_irq_e3", 1'b1);
        rdchk("lat_claim", A_CLAIM, 32'h1);
        src_irq[0] = 1'b0;
        wr(A_CLAIM, 32'h1);
        rdchk("cmp_pend", A_PEND, 32'h0);
        irqchk("cmp_irq_k", 1'b1);
        tick(1);
        irqchk("cmp_irq_k1", 1'b0);

        // Set/clear collision on source 2
        wr(A_EN, 32'h05);
        wr(A_MODE, 32'h05);
        src_irq[2] = 1'b1;
        tick(2);
        wr(A_PEND, 32'h04);
        rdchk("col_pend", A_PEND, 32'h04);
        tick(1);
        irqchk("col_irq", 1'b1);
        src_irq = '0;
        wr(A_PEND, 32'h04);
        rdchk("w1c_pend", A_PEND, 32'h0);
        tick(1);
        irqchk("w1c_irq", 1'b0);

        // Level mode on source 3
        wr(A_EN, 32'h08);
        wr(A_MODE, 32'h00);
        tick(3);
        src_irq[3] = 1'b1;
        tick(4);
        rdchk("lvl_pend", A_PEND, 32'h08);
        irqchk("lvl_irq", 1'b1);
        wr(A_PEND, 32'h08);
        rdchk("lvl_w1c", A_PEND, 32'h08);
        src_irq[3] = 1'b0;
        tick(2);
        rdchk("lvl_hold", A_PEND, 32'h08);
        tick(1);
        rdchk("lvl_drop", A_PEND, 32'h0);
        irqchk("lvl_irq_hi", 1'b1);
        tick(1);
        irqchk("lvl_irq_lo", 1'b0);

        // Priority among 1, 4, 6
        wr(A_MODE, 32'hFF);
        wr(A_EN, 32'hFF);
        src_irq = 8'h52;
        tick(3);
        rdchk("pri_pend", A_PEND, 32'h52);
        rdchk("pri_c1", A_CLAIM, 32'd2);
        tick(1);
        rdchk("pri_status", A_STATUS, 32'h0301);
        wr(A_CLAIM, 32'd2);
        rdchk("pri_c2", A_CLAIM, 32'd5);
        wr(A_CLAIM, 32'd5);
        rdchk("pri_c3", A_CLAIM, 32'd7);
        wr(A_CLAIM, 32'd7);
        rdchk("pri_c4", A_CLAIM, 32'd0);
        src_irq = '0;
        tick(2);
        src_irq = 8'h52;
        tick(3);
        rdchk("pri_c5", A_CLAIM, 32'd2);

        // Enable-gated hold
        wr(A_EN, 32'h00);
        rdchk("hold_pend", A_PEND, 32'h52);
        tick(1);
        irqchk("hold_irq", 1'b0);
        wr(A_EN, 32'hFF);
        irqchk("reen_irq0", 1'b0);
        tick(1);
        irqchk("reen_irq1", 1'b1);

        // Illegal CLAIM values
        wr(A_CLAIM, 32'd9);
        wr(A_CLAIM, 32'd0);
        rdchk("bad_claim", A_PEND, 32'h52);

        // Address window and unimplemented bits
        wr(BASE + 32'h20, 32'h0);
        chk("oow_hit", {31'd0, rd_hit}, 32'd0);
        chk("oow_rd", rd_data, 32'd0);
        wr(BASE - 32'h4, 32'h0);
        rdchk("oow_en", A_EN, 32'hFF);
        wr(A_EN, 32'hFFFF_FFFF);
        rdchk("en_mask", A_EN, 32'hFF);
        rdchk("rsvd_rd", BASE + 32'h14, 32'h0);

        // Reset mid-operation
        src_irq = '0;
        wr(A_PEND, 32'hFF);
        tick(3);
        src_irq = 8'h05;
        tick(4);
        rdchk("pre_rst_pend", A_PEND, 32'h05);
        irqchk("pre_rst_irq", 1'b1);
        iobus_addr = A_PEND;
        RST_N = 1'b0;
        #1;
        irqchk("mid_rst_irq", 1'b0);
        chk("mid_rst_pend", rd_data, 32'h0);
        rdchk("mid_rst_en", A_EN, 32'h0);
        tick(2);
        RST_N = 1'b1;
        tick(5);
        irqchk("post_rst_irq", 1'b0);
        rdchk("post_rst_en", A_EN, 32'h0);

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
